// File: rtl/rsa_modexp.sv
// rsa_modexp: 64-bit modular exponentiation, result = base^exponent mod modulus.
// Right-to-left binary method; every modular multiply is an interleaved
// shift-add (one multiplier bit per cycle, 64 cycles), so no wide product exists.
module rsa_modexp (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] base,
  input  logic [63:0] exponent,
  input  logic [63:0] modulus,
  output logic [63:0] result,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned W  = 64;
  localparam int unsigned XW = W + 2;
  localparam int unsigned CW = 6;

  // NEXT is a zero-cycle decision folded into the last cycle of LOAD/MUL/SQR.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MUL,
    S_SQR,
    S_FIN
  } state_t;

  state_t state, next_state;

  logic [W-1:0]  b_reg;      // squaring operand B (also the multiplicand of every step)
  logic [W-1:0]  e_reg;      // remaining exponent E
  logic [W-1:0]  n_reg;      // modulus n
  logic [W-1:0]  r_reg;      // accumulator R
  logic [W-1:0]  acc;        // partial result of the running multiply
  logic [W-1:0]  mplier;     // multiplier, consumed MSB first
  logic [CW-1:0] cnt;        // bit index of the running multiply
  logic          err_reg;

  logic          accept, load, step, last, op_start, fin;
  logic          bad;
  logic [W-1:0]  r_init;
  logic [W-1:0]  acc_next;
  logic [W-1:0]  mplier_src;
  logic [XW-1:0] nx, dbl, dbl_red, sum, sum_red;

  // Operand legality and accumulator start value
  always_comb begin
    bad    = (n_reg == '0) || (b_reg >= n_reg);
    r_init = (n_reg == W'(1)) ? '0 : W'(1);
  end

  // One shift-add step: acc = 2*acc mod n, then + B mod n if the multiplier bit is set
  always_comb begin
    nx       = {2'b00, n_reg};
    dbl      = {1'b0, acc, 1'b0};
    dbl_red  = (dbl >= nx) ? (dbl - nx) : dbl;
    sum      = dbl_red + {2'b00, b_reg};
    sum_red  = (sum >= nx) ? (sum - nx) : sum;
    acc_next = mplier[W-1] ? W'(sum_red) : W'(dbl_red);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: if (start) next_state = S_LOAD;
      S_LOAD: begin
        if (bad || (e_reg == '0)) next_state = S_FIN;
        else if (e_reg[0])        next_state = S_MUL;
        else                      next_state = S_SQR;
      end
      S_MUL: if (cnt == CW'(W - 1)) next_state = (|e_reg[W-1:1]) ? S_SQR : S_FIN;
      S_SQR: if (cnt == CW'(W - 1)) next_state = e_reg[1] ? S_MUL : S_SQR;
      S_FIN: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath controls decoded from the current and next state
  always_comb begin
    accept     = (state == S_IDLE) && start;
    load       = (state == S_LOAD);
    step       = (state == S_MUL) || (state == S_SQR);
    last       = step && (cnt == CW'(W - 1));
    fin        = (state == S_FIN);
    op_start   = ((next_state == S_MUL) || (next_state == S_SQR)) && (load || last);
    mplier_src = b_reg;
    if (next_state == S_MUL) mplier_src = load ? r_init : r_reg;
    else if (state == S_SQR) mplier_src = acc_next;
  end

  // Operand capture, exponent scan and modular multiply datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_reg   <= '0;
      e_reg   <= '0;
      n_reg   <= '0;
      r_reg   <= '0;
      acc     <= '0;
      mplier  <= '0;
      cnt     <= '0;
      err_reg <= 1'b0;
    end else begin
      if (accept) begin
        b_reg   <= base;
        e_reg   <= exponent;
        n_reg   <= modulus;
        err_reg <= 1'b0;
      end
      if (load) begin
        r_reg   <= r_init;
        err_reg <= bad;
      end
      if (step) begin
        acc    <= acc_next;
        mplier <= mplier << 1;
        cnt    <= cnt + CW'(1);
      end
      if (last) begin
        if (state == S_MUL) begin
          r_reg <= acc_next;
        end else begin
          b_reg <= acc_next;
          e_reg <= e_reg >> 1;
        end
      end
      if (op_start) begin
        acc    <= '0;
        cnt    <= '0;
        mplier <= mplier_src;
      end
    end
  end

  // Registered handshake and result; busy stays up across a back-to-back accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
    end else begin
      done  <= fin;
      error <= fin && err_reg;
      if (fin)         result <= err_reg ? '0 : r_reg;
      if (accept)      busy   <= 1'b1;
      else if (done)   busy   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rsa_modexp.sv
// tb_rsa_modexp: directed and randomized checks of rsa_modexp against a
// plain-arithmetic modular exponentiation and latency model.
module tb_rsa_modexp;

  localparam int TMO = 20000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] base, exponent, modulus;
  logic [63:0] result;
  logic        busy, done, error;

  int n_tests = 0;
  int n_fail  = 0;

  rsa_modexp dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base     (base),
    .exponent (exponent),
    .modulus  (modulus),
    .result   (result),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: square-and-multiply with 128-bit products
  function automatic logic [63:0] ref_modexp(input logic [63:0] b, input logic [63:0] e,
                                             input logic [63:0] n);
    logic [127:0] r, x, nn;
    logic [63:0]  k;
    if (n == 64'd0 || b >= n) return 64'd0;
    nn = {64'd0, n};
    r  = 128'd1 % nn;
    x  = {64'd0, b};
    k  = e;
    while (k != 64'd0) begin
      if (k[0]) r = (r * x) % nn;
      x = (x * x) % nn;
      k = k >> 1;
    end
    return r[63:0];
  endfunction

  function automatic int ref_latency(input logic [63:0] b, input logic [63:0] e,
                                     input logic [63:0] n);
    int bl;
    if (n == 64'd0 || b >= n || e == 64'd0) return 2;
    bl = 0;
    for (int i = 0; i < 64; i++) if (e[i]) bl = i + 1;
    return 2 + 64 * ($countones(e) + bl - 1);
  endfunction

  // One run from accept to done; optionally pokes start mid-run with other operands
  task automatic do_run(input string tag, input logic [63:0] b_i, input logic [63:0] e_i,
                        input logic [63:0] n_i, input bit poke, output logic [63:0] res_o);
    int   lat;
    logic got, busy_at_done, busy_drop, err_o, busy_after;
    logic exp_err;
    @(negedge clk);
    base = b_i; exponent = e_i; modulus = n_i; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base = {$urandom, $urandom}; exponent = {$urandom, $urandom}; modulus = {$urandom, $urandom};
    lat = 0; got = 1'b0; busy_drop = 1'b0; busy_at_done = 1'b0; err_o = 1'b0; res_o = '0;
    while (!got && lat < TMO) begin
      if (poke && lat == 50) begin
        base = 64'd2; exponent = 64'd10; modulus = 64'd1000; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (done) begin
        got = 1'b1; res_o = result; err_o = error; busy_at_done = busy;
      end else if (!busy) begin
        busy_drop = 1'b1;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    @(posedge clk); #1;
    busy_after = busy;
    exp_err = (n_i == 64'd0) || (b_i >= n_i);
    check({tag, "_latency"}, 64'(lat), 64'(ref_latency(b_i, e_i, n_i)));
    check({tag, "_result"}, res_o, ref_modexp(b_i, e_i, n_i));
    check({tag, "_error"}, 64'(err_o), 64'(exp_err));
    check({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd1);
    check({tag, "_busy_held"}, 64'(busy_drop), 64'd0);
    check({tag, "_busy_after"}, 64'(busy_after), 64'd0);
  endtask

  initial begin
    logic [63:0] res, enc, nr, br, er;
    logic [5:0]  dmask;
    logic        busy3;
    int          seen;

    rst = 1'b1; start = 1'b1; base = 64'd5; exponent = 64'd3; modulus = 64'd7;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_error", 64'(error), 64'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;

    // Normal run, with a start pulse while busy that must be ignored
    do_run("pow4_13", 64'd4, 64'd13, 64'd497, 1'b1, res);
    check("pow4_13_spec", res, 64'd445);
    do_run("pow2_10", 64'd2, 64'd10, 64'd1000, 1'b0, res);
    check("pow2_10_spec", res, 64'd24);

    // RSA round trip
    do_run("rsa_enc", 64'd65, 64'd17, 64'd3233, 1'b0, enc);
    check("rsa_enc_spec", enc, 64'd2790);
    do_run("rsa_dec", enc, 64'd2753, 64'd3233, 1'b0, res);
    check("rsa_dec_spec", res, 64'd65);

    // Boundaries and errors
    do_run("exp_zero", 64'd3, 64'd0, 64'd7, 1'b0, res);
    check("exp_zero_spec", res, 64'd1);
    do_run("mod_one", 64'd0, 64'd5, 64'd1, 1'b0, res);
    do_run("mod_zero", 64'd5, 64'd9, 64'd0, 1'b0, res);
    do_run("base_ge_mod", 64'd10, 64'd3, 64'd7, 1'b0, res);

    // Randomized operands
    for (int i = 0; i < 8; i++) begin
      nr = {$urandom, $urandom};
      if (nr < 64'd2) nr = 64'd3;
      br = {$urandom, $urandom} % nr;
      er = (i == 7) ? {$urandom, $urandom} : 64'($urandom_range(32'hFFFFF, 1));
      do_run($sformatf("rand%0d", i), br, er, nr, 1'b0, res);
    end
    nr = 64'($urandom_range(32'hFFFF, 2));
    do_run("rand_err", nr + 64'($urandom_range(100, 0)), 64'd7, nr, 1'b0, res);

    // Reset 100 cycles into a run
    do_run("pre_rst", 64'd2, 64'd10, 64'd1000, 1'b0, res);
    @(negedge clk);
    base = 64'd4; exponent = 64'd13; modulus = 64'd497; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_result", result, 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_busy", 64'(busy), 64'd0);
    check("rst_hold_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    seen = 0;
    repeat (400) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("no_done_after_rst", 64'(seen), 64'd0);
    do_run("restart", 64'd4, 64'd13, 64'd497, 1'b0, res);
    check("restart_spec", res, 64'd445);

    // Start held high: re-accepted in the first IDLE cycle after FIN
    @(negedge clk);
    base = 64'd3; exponent = 64'd0; modulus = 64'd7; start = 1'b1;
    @(posedge clk);
    dmask = '0; busy3 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      dmask[i-1] = done;
      if (i == 3) busy3 = busy;
    end
    start = 1'b0;
    check("b2b_done_pattern", 64'(dmask), 64'(6'b010010));
    check("b2b_busy", 64'(busy3), 64'd1);
    check("b2b_result", result, 64'd1);
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rsa_modexp.md
RSA_MODEXP -- requirements
Module: rsa_modexp

Interface
REQ-001 SHALL provide the port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 SHALL provide the port `rst`: input, 1 bit, asynchronous active-high reset.
REQ-003 SHALL provide the port `start`: input, 1 bit, request pulse; sampled only in IDLE.
REQ-004 SHALL provide the port `base`: input, 64 bits, message or ciphertext operand; captured when `start` is accepted.
REQ-005 SHALL provide the port `exponent`: input, 64 bits, public or private key exponent; captured when `start` is accepted.
REQ-006 SHALL provide the port `modulus`: input, 64 bits, RSA modulus n; captured when `start` is accepted.
REQ-007 SHALL provide the port `result`: output, 64 bits, `base`^`exponent` mod `modulus`; held until the next accepted `start`.
REQ-008 SHALL provide the port `busy`: output, 1 bit, high from the accept cycle until the cycle `done` pulses.
REQ-009 SHALL provide the port `done`: output, 1 bit, one-cycle completion pulse.
REQ-010 SHALL provide the port `error`: output, 1 bit, one-cycle pulse coincident with `done` for an illegal operand.

Function
REQ-011 SHALL implement states IDLE, LOAD, MUL, SQR, NEXT, FIN.
- IDLE -> LOAD on `start`.
- LOAD -> FIN on an error or zero exponent; otherwise LOAD -> NEXT.
- NEXT -> MUL if exponent LSB=1, else NEXT -> SQR.
- MUL -> SQR when the remaining exponent >> 1 != 0, else MUL -> FIN.
- SQR -> NEXT after shifting the exponent right 1.
- FIN -> IDLE.
REQ-012 SHALL make NEXT a zero-cycle decision folded into the preceding state's last cycle; it adds no cycle.
REQ-013 SHALL capture `base`, `exponent` and `modulus` in the accept cycle (IDLE with `start`=1); input changes afterwards have no effect on the run.
REQ-014 SHALL initialise in LOAD: accumulator R = 1 mod n (0 when n=1), B = base, E = exponent.
REQ-015 SHALL perform each modular multiply (MUL: R = R*B mod n; SQR: B = B*B mod n) as an interleaved shift-add over multiplier bits 63..0, one bit per cycle, exactly 64 cycles.
- Per bit: acc = 2*acc mod n, then acc = acc + a mod n if the bit is set.
- Each step uses a 66-bit intermediate and at most one conditional subtract of n per operation.
REQ-016 SHALL never generate a full 64x64 multiplier product.
REQ-017 SHALL skip SQR after the highest set exponent bit (MSB-terminating right-to-left binary method).
REQ-018 SHALL give latency `done` = L cycles after the accept edge, where L = 2 + 64*(popcount(E) + bitlen(E) - 1) for E != 0, and L = 2 for E = 0 or error.
REQ-019 SHALL flag an error when `modulus` = 0 or `base` >= `modulus`.
- Response: `error`=1 and `done`=1 in FIN, `result` = 0, no MUL/SQR cycles.
REQ-020 SHALL return `result` = 1 when `exponent` = 0 and `modulus` > 1.
REQ-021 SHALL return `result` = 0 for any exponent when `modulus` = 1, with no error.
REQ-022 SHALL update `result` in the same cycle `done` pulses.
REQ-023 SHALL deassert `busy` in the cycle after `done`.
REQ-024 SHALL ignore `start` while `busy`=1; no queuing and no effect on the current run.
REQ-025 SHALL accept a `start` held high continuously again in the first IDLE cycle after FIN; back-to-back runs have a one-cycle IDLE gap.
REQ-026 SHALL keep all arithmetic unsigned, with every intermediate < 2n before its conditional subtract.

Reset
REQ-027 SHALL, on `rst`=1, immediately and asynchronously force state IDLE and `result`=0, `busy`=0, `done`=0, `error`=0, and clear all internal operand registers.
REQ-028 SHALL, on reset asserted mid-run, abandon the run with no `done` pulse; the first `start` after `rst` deasserts begins a fresh run.
REQ-029 SHALL hold all outputs at reset values while `rst`=1 regardless of `start`.

Verification
REQ-030 SHALL cover a normal run:
- Stimulus: base=4, exponent=13, modulus=497.
- Response: `done` at L=386, `result`=445, `error`=0.
REQ-031 SHALL cover an RSA round trip:
- Stimulus: n=3233, e=17, d=2753, message 65.
- Response: encrypt gives 2790; decrypting 2790 gives 65.
REQ-032 SHALL cover the zero-exponent boundary:
- Stimulus: base=3, exponent=0, modulus=7.
- Response: `done` at L=2, `result`=1.
- Stimulus: modulus=1, exponent=5.
- Response: `result`=0, `error`=0.
REQ-033 SHALL cover error cases:
- Stimulus: modulus=0.
- Response: `done`+`error` at L=2, `result`=0.
- Stimulus: base=10, modulus=7.
- Response: `done`+`error` at L=2, `result`=0.
REQ-034 SHALL cover start while busy:
- Stimulus: during the 4^13 run, pulse `start` with base=2, exponent=10, modulus=1000.
- Response: the first run's result is unchanged (445).
- Stimulus: a later accepted `start` with the same operands.
- Response: `result`=24.
REQ-035 SHALL cover reset mid-operation:
- Stimulus: assert `rst` 100 cycles into a run.
- Response: outputs 0 immediately and no `done` pulse.
- Stimulus: restart with base=4, exponent=13, modulus=497.
- Response: `result`=445 at L=386.
